// File: rtl/serial_mmio_port.sv
// Memory-mapped byte-serial port: CPU register window over TX/RX FIFOs with
// valid/rden ingress from the device, ready/wren egress to it, and sticky error flags.
module serial_mmio_port #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        addr_in,
  input  logic              rd_en_in,
  input  logic              wr_en_in,
  input  logic [31:0]       wdata_in,
  output logic [31:0]       rdata_out,
  input  logic [DATA_W-1:0] serial_in,
  input  logic              serial_valid_in,
  output logic              serial_rden_out,
  input  logic              serial_ready_in,
  output logic [DATA_W-1:0] serial_out,
  output logic              serial_wren_out
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  reg_e reg_sel;
  assign reg_sel = reg_e'(addr_in);

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];

  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
  logic [31:0]      rdata_q, rdata_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic data_rd, data_wr, ctrl_wr;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic rx_flush, tx_flush, sticky_clr;
  logic unused_wdata;

  assign unused_wdata = ^wdata_in;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));

  assign data_rd    = rd_en_in && (reg_sel == REG_DATA);
  assign data_wr    = wr_en_in && (reg_sel == REG_DATA);
  assign ctrl_wr    = wr_en_in && (reg_sel == REG_CTRL);
  assign sticky_clr = ctrl_wr && wdata_in[0];
  assign rx_flush   = ctrl_wr && wdata_in[1];
  assign tx_flush   = ctrl_wr && wdata_in[2];

  // Full checks use the pre-edge count; a same-cycle pop frees a TX slot but not an RX one.
  assign serial_rden_out = serial_valid_in && !rx_full;
  assign serial_wren_out = !tx_empty && serial_ready_in;
  assign serial_out      = tx_mem_q[tx_rptr_q];

  assign rx_push = serial_rden_out;
  assign rx_pop  = data_rd && !rx_empty;
  assign tx_pop  = serial_wren_out;
  assign tx_push = data_wr && (!tx_full || tx_pop);

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // Clear wins over a same-cycle set.
  always_comb begin
    rx_uf_d = sticky_clr ? 1'b0 : (rx_uf_q || (data_rd && rx_empty));
    tx_of_d = sticky_clr ? 1'b0 : (tx_of_q || (data_wr && tx_full && !tx_pop));
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en_in) begin
      rdata_d = '0;
      case (reg_sel)
        REG_DATA: begin
          if (!rx_empty) rdata_d[DATA_W-1:0] = rx_mem_q[rx_rptr_q];
        end
        REG_STATUS: begin
          rdata_d[0]           = !rx_empty;
          rdata_d[1]           = !tx_full;
          rdata_d[2]           = rx_uf_q;
          rdata_d[3]           = tx_of_q;
          rdata_d[8 +: RX_CW]  = rx_cnt_q;
          rdata_d[16 +: TX_CW] = tx_cnt_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_uf_q   <= 1'b0;
      tx_of_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_uf_q   <= rx_uf_d;
      tx_of_q   <= tx_of_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push && !rx_flush) rx_mem_q[rx_wptr_q] <= serial_in;
    if (tx_push && !tx_flush) tx_mem_q[tx_wptr_q] <= wdata_in[DATA_W-1:0];
  end

  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_serial_mmio_port.sv
// Directed bench for serial_mmio_port: register map, FIFO flow control, sticky flags, flush, reset.
module tb_serial_mmio_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  addr_in;
  logic        rd_en_in;
  logic        wr_en_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;
  logic [7:0]  serial_in;
  logic        serial_valid_in;
  logic        serial_rden_out;
  logic        serial_ready_in;
  logic [7:0]  serial_out;
  logic        serial_wren_out;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  serial_mmio_port #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .addr_in         (addr_in),
    .rd_en_in        (rd_en_in),
    .wr_en_in        (wr_en_in),
    .wdata_in        (wdata_in),
    .rdata_out       (rdata_out),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_rden_out (serial_rden_out),
    .serial_ready_in (serial_ready_in),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    addr_in = a; wdata_in = d; wr_en_in = 1'b1;
    tick();
    wr_en_in = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    addr_in = a; rd_en_in = 1'b1;
    tick();
    rd_en_in = 1'b0;
    d = rdata_out;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; addr_in = 2'd0; rd_en_in = 1'b0; wr_en_in = 1'b0; wdata_in = '0;
    serial_in = '0; serial_valid_in = 1'b0; serial_ready_in = 1'b1;
    #23;
    n_total++;
    if (rdata_out !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata_out);
    else n_pass++;
    n_total++;
    if (serial_wren_out !== 1'b0 || serial_rden_out !== 1'b0)
      $display("FAIL reset_strobes: wren=%b rden=%b want 0 0", serial_wren_out, serial_rden_out);
    else n_pass++;
    reset = 1'b0;
    tick();
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0002) $display("FAIL reset_status: got %h want 00000002", d);
    else n_pass++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic [7:0]  exp;
    serial_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(2'd0, 32'h41 + i);
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0004_0008) $display("FAIL tx_full_status: got %h want 00040008", d);
    else n_pass++;
    serial_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      exp = 8'h41 + 8'(i);
      n_total++;
      if (i < 4) begin
        if (serial_wren_out !== 1'b1 || serial_out !== exp)
          $display("FAIL tx_drain_%0d: wren=%b out=%h want 1 %h", i, serial_wren_out, serial_out, exp);
        else n_pass++;
      end else begin
        if (serial_wren_out !== 1'b0) $display("FAIL tx_drain_end: wren=%b want 0", serial_wren_out);
        else n_pass++;
      end
      tick();
    end
    cpu_write(2'd2, 32'h1);
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0002) $display("FAIL tx_clear_status: got %h want 00000002", d);
    else n_pass++;
  endtask

  task automatic test_rx_fill_and_read();
    logic [31:0] d;
    logic        popped;
    serial_in = 8'h10; serial_valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      popped = serial_rden_out;
      n_total++;
      if (popped !== (i < 4)) $display("FAIL rx_rden_%0d: got %b want %b", i, popped, (i < 4));
      else n_pass++;
      tick();
      if (popped) serial_in = serial_in + 8'h1;
    end
    serial_valid_in = 1'b0;
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0403) $display("FAIL rx_full_status: got %h want 00000403", d);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd0, d);
      n_total++;
      if (d !== 32'h10 + i) $display("FAIL rx_data_%0d: got %h want %h", i, d, 32'h10 + i);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    cpu_read(2'd0, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL uf_data: got %h want 00000000", d);
    else n_pass++;
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0006) $display("FAIL uf_status: got %h want 00000006", d);
    else n_pass++;
    cpu_write(2'd2, 32'h1);
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0002) $display("FAIL uf_clear: got %h want 00000002", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'h99;
    serial_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(2'd0, 32'hA0 + i);
    serial_ready_in = 1'b1;
    addr_in = 2'd0; wdata_in = 32'h99; wr_en_in = 1'b1;
    #2;
    n_total++;
    if (serial_wren_out !== 1'b1 || serial_out !== 8'hA0)
      $display("FAIL b2b_pop: wren=%b out=%h want 1 a0", serial_wren_out, serial_out);
    else n_pass++;
    tick();
    wr_en_in = 1'b0; serial_ready_in = 1'b0;
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0004_0000) $display("FAIL b2b_status: got %h want 00040000", d);
    else n_pass++;
    serial_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_total++;
      if (serial_wren_out !== 1'b1 || serial_out !== exp[i])
        $display("FAIL b2b_drain_%0d: wren=%b out=%h want 1 %h", i, serial_wren_out, serial_out, exp[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    serial_in = 8'h55; serial_valid_in = 1'b1;
    tick(); tick();
    serial_valid_in = 1'b0;
    cpu_write(2'd2, 32'h2);
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0002) $display("FAIL rx_flush_status: got %h want 00000002", d);
    else n_pass++;
    cpu_read(2'd0, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rx_flush_data: got %h want 00000000", d);
    else n_pass++;
    cpu_write(2'd2, 32'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    serial_ready_in = 1'b0;
    cpu_write(2'd0, 32'h77);
    cpu_write(2'd0, 32'h78);
    cpu_read(2'd1, d);
    serial_ready_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (serial_wren_out !== 1'b0 || rdata_out !== 32'h0)
      $display("FAIL midreset_outputs: wren=%b rdata=%h want 0 00000000", serial_wren_out, rdata_out);
    else n_pass++;
    #1;
    reset = 1'b0;
    tick();
    cpu_read(2'd1, d);
    n_total++;
    if (d !== 32'h0000_0002) $display("FAIL midreset_status: got %h want 00000002", d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_fill_and_read();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
